// File: rtl/button_debouncer.sv
// Push-button conditioner: multi-flop synchroniser followed by a counter-qualified
// press/release FSM, with a stable flag and a saturating bounce counter for debug.
module button_debouncer #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_WIDTH       = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btnRaw,
    input  logic       bounceClr,
    output logic       btnClean,
    output logic       btnStable,
    output logic [7:0] bounceCount
);

    localparam logic [1:0] S_RELEASED    = 2'd0;
    localparam logic [1:0] S_PRESS_CHK   = 2'd1;
    localparam logic [1:0] S_PRESSED     = 2'd2;
    localparam logic [1:0] S_RELEASE_CHK = 2'd3;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   btn_sync;
    logic [1:0]             state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   clean_q, clean_d;
    logic                   stable_q, stable_d;
    logic [7:0]             bcnt_q, bcnt_d;
    logic                   bounce;

    assign btn_sync = sync_q[SYNC_STAGES-1];

    // Synchroniser idles high so a button held through reset is seen as a fresh press.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '1;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop
            // samples pre-edge values; blocking here would collapse the chain.
            sync_q <= {sync_q[SYNC_STAGES-2:0], btnRaw};
        end
    end

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // through the case can leave one unassigned and infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        clean_d = clean_q;
        bounce  = 1'b0;
        case (state_q)
            S_RELEASED: begin
                if (!btn_sync) begin
                    state_d = S_PRESS_CHK;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d = '0;
                end
            end
            S_PRESS_CHK: begin
                if (btn_sync) begin
                    state_d = S_RELEASED;
                    cnt_d   = '0;
                    bounce  = 1'b1;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = S_PRESSED;
                    cnt_d   = '0;
                    clean_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_PRESSED: begin
                if (btn_sync) begin
                    state_d = S_RELEASE_CHK;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d = '0;
                end
            end
            S_RELEASE_CHK: begin
                if (!btn_sync) begin
                    state_d = S_PRESSED;
                    cnt_d   = '0;
                    bounce  = 1'b1;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = S_RELEASED;
                    cnt_d   = '0;
                    clean_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = S_RELEASED;
                cnt_d   = '0;
                clean_d = 1'b1;
            end
        endcase
    end

    assign stable_d = (state_d == S_RELEASED) || (state_d == S_PRESSED);

    // Clear has priority over a simultaneous bounce; the count sticks at 255.
    always_comb begin
        bcnt_d = bcnt_q;
        if (bounceClr) begin
            bcnt_d = '0;
        end else if (bounce && (bcnt_q != 8'hFF)) begin
            bcnt_d = bcnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_RELEASED;
            cnt_q    <= '0;
            clean_q  <= 1'b1;
            stable_q <= 1'b1;
            bcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            clean_q  <= clean_d;
            stable_q <= stable_d;
            bcnt_q   <= bcnt_d;
        end
    end

    assign btnClean    = clean_q;
    assign btnStable   = stable_q;
    assign bounceCount = bcnt_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Randomised and directed bench for button_debouncer, checked against a run-length
// reference model of the debounce rules.
module tb_button_debouncer;

    localparam int SYNC = 2;
    localparam int DEB  = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       btnRaw = 1'b1;
    logic       bounceClr = 1'b0;
    logic       btnClean;
    logic       btnStable;
    logic [7:0] bounceCount;

    int n_vec = 0;
    int n_err = 0;

    button_debouncer #(
        .SYNC_STAGES    (SYNC),
        .DEBOUNCE_CYCLES(DEB),
        .CNT_WIDTH      (3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btnRaw     (btnRaw),
        .bounceClr  (bounceClr),
        .btnClean   (btnClean),
        .btnStable  (btnStable),
        .bounceCount(bounceCount)
    );

    always #5 clk = ~clk;

    // Reference: accepted level, length of the current run of disagreeing
    // synchronised samples, and the raw samples still in flight to the FSM.
    logic       m_clean;
    int         m_run;
    logic [7:0] m_bcnt;
    logic       m_hist[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_clean = 1'b1;
        m_run   = 0;
        m_bcnt  = 8'd0;
        m_hist.delete();
        for (int i = 0; i < SYNC; i++) m_hist.push_back(1'b1);
    endfunction

    function automatic bit will_bounce();
        return (m_run > 0) && (m_hist[0] == m_clean);
    endfunction

    function automatic void model_edge(input logic raw, input logic clr);
        logic s;
        bit   bnc;
        s = m_hist.pop_front();
        m_hist.push_back(raw);
        bnc = 1'b0;
        if (s != m_clean) begin
            m_run++;
            if (m_run == DEB) begin
                m_clean = s;
                m_run   = 0;
            end
        end else begin
            bnc   = (m_run > 0);
            m_run = 0;
        end
        if (clr) m_bcnt = 8'd0;
        else if (bnc && m_bcnt != 8'd255) m_bcnt = m_bcnt + 8'd1;
    endfunction

    task automatic step(input logic raw, input logic clr);
        @(negedge clk);
        btnRaw    = raw;
        bounceClr = clr;
        @(posedge clk);
        model_edge(raw, clr);
        #1;
        check("clean",  btnClean,    m_clean);
        check("stable", btnStable,   (m_run == 0));
        check("bcnt",   bounceCount, m_bcnt);
    endtask

    // Asserts reset between edges and checks outputs before any clock arrives.
    task automatic do_reset();
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("rst_clean",  btnClean,    1);
        check("rst_stable", btnStable,   1);
        check("rst_bcnt",   bounceCount, 0);
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        model_reset();
    endtask

    // Edges from the first sample of the new level until btnClean reaches target.
    task automatic measure(input logic raw, input logic target, input string tag, input int exp);
        int e;
        for (e = 0; e < 20; e++) begin
            step(raw, 1'b0);
            if (btnClean == target) break;
        end
        check(tag, e, exp);
    endtask

    initial begin
        bit found;
        model_reset();
        do_reset();

        // Clean press, then release with a one-sample bounce.
        repeat (3) step(1'b1, 1'b0);
        measure(1'b0, 1'b0, "press_lat", SYNC + DEB - 1);
        check("press_bcnt", bounceCount, 0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        measure(1'b1, 1'b1, "release_lat", SYNC + DEB - 1);
        check("release_bcnt", bounceCount, 1);

        // Three-sample low pulse is one short of acceptance.
        do_reset();
        repeat (3) step(1'b0, 1'b0);
        repeat (6) step(1'b1, 1'b0);
        check("short_clean", btnClean, 1);
        check("short_bcnt",  bounceCount, 1);

        // Saturation, then clear on the same edge as a bounce.
        do_reset();
        repeat (260) begin
            step(1'b0, 1'b0);
            step(1'b1, 1'b0);
        end
        repeat (3) step(1'b1, 1'b0);
        check("sat_bcnt", bounceCount, 255);
        step(1'b0, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (will_bounce()) begin
                step(1'b1, 1'b1);
                found = 1'b1;
            end else begin
                step(1'b1, 1'b0);
            end
        end
        check("clr_found", found, 1);
        check("clr_bcnt",  bounceCount, 0);

        // Reset in the middle of a press check, button held through it.
        do_reset();
        repeat (4) step(1'b0, 1'b0);
        check("midchk_stable", btnStable, 0);
        do_reset();
        measure(1'b0, 1'b0, "held_lat", SYNC + DEB - 1);

        // Single-sample glitches every third cycle.
        do_reset();
        repeat (10) begin
            step(1'b0, 1'b0);
            step(1'b1, 1'b0);
            step(1'b1, 1'b0);
        end
        repeat (4) step(1'b1, 1'b0);
        check("glitch_clean", btnClean, 1);
        check("glitch_bcnt",  bounceCount, 10);

        // Random segments of varying length, occasional clears and resets.
        do_reset();
        repeat (300) begin
            logic lvl;
            int   len;
            lvl = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 7);
            for (int i = 0; i < len; i++) step(lvl, 1'($urandom_range(0, 24) == 0));
            if ($urandom_range(0, 59) == 0) do_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/button_debouncer.md
Name: button_debouncer

Overview:
- Front-end conditioning stage for one FPGA push button. It sits directly upstream of the button shaper and drives that block's active-low button sense input.
- Synchronises the raw, bouncing, active-low pad signal into the clk domain with a multi-flop chain.
- Filters it with a counter-qualified state machine, so the shaper only ever sees a clean, single-transition level per physical press/release.
- Also provides a stable flag and a saturating bounce counter for debug LEDs.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops on btnRaw (legal values ≥2).
- DEBOUNCE_CYCLES, 500000, consecutive identical synchronised samples needed to accept a new level (legal values ≥2; 10 ms at 50 MHz).
- CNT_WIDTH, 20, width of the debounce counter; must satisfy 2^CNT_WIDTH > DEBOUNCE_CYCLES-1.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- btnRaw  input  1  raw pad signal, active-low (0 = pressed), asynchronous to clk.
- bounceClr  input  1  synchronous clear of bounceCount, active-high.
- btnClean  output  1  debounced level, active-low (0 = pressed); feeds the shaper's button sense input.
- btnStable  output  1  1 when the FSM is in a settled state (S_RELEASED or S_PRESSED).
- bounceCount  output  8  saturating count of rejected transitions (bounces).

Behaviour:
- Reset (async, active-high, takes effect immediately without a clock):
  - all synchroniser flops = 1
  - state = S_RELEASED, cnt = 0
  - btnClean = 1, btnStable = 1, bounceCount = 0
- Synchroniser: btnSync is the last flop of a SYNC_STAGES-deep shift chain clocked by clk. Only btnSync is used downstream of the chain.
- FSM states: S_RELEASED, S_PRESS_CHK, S_PRESSED, S_RELEASE_CHK.
- S_RELEASED:
  - btnSync=0 -> S_PRESS_CHK, cnt<=1.
  - Otherwise stay, cnt<=0.
- S_PRESS_CHK:
  - btnSync=0 and cnt==DEBOUNCE_CYCLES-1 -> S_PRESSED, cnt<=0, btnClean<=0.
  - btnSync=0 and cnt<DEBOUNCE_CYCLES-1 -> stay, cnt<=cnt+1.
  - btnSync=1 -> S_RELEASED, cnt<=0, bounce event.
- S_PRESSED: mirror of S_RELEASED with btnSync=1 -> S_RELEASE_CHK, cnt<=1.
- S_RELEASE_CHK:
  - btnSync=1 and cnt==DEBOUNCE_CYCLES-1 -> S_RELEASED, cnt<=0, btnClean<=1.
  - btnSync=1 and cnt<DEBOUNCE_CYCLES-1 -> stay, cnt<=cnt+1.
  - btnSync=0 -> S_PRESSED, cnt<=0, bounce event.
- Unreachable state encodings -> S_RELEASED, cnt<=0, btnClean<=1.
- Output registering:
  - btnClean is a register, changed only on the accepting transition; it never glitches.
  - btnStable is registered: 1 in S_RELEASED/S_PRESSED, 0 in CHK states. It updates on the same edge as the state.
- Latency: if btnRaw is 0 at rising edge k and stays 0, btnClean falls on edge k+SYNC_STAGES+DEBOUNCE_CYCLES-1. Release latency is identical.
- Rejection: a level must appear on DEBOUNCE_CYCLES consecutive btnSync samples. Any shorter pulse produces no btnClean change.
- bounceCount:
  - +1 per bounce event; saturates at 255 (no wrap).
  - bounceClr=1 clears it on the next edge.
  - bounceClr and a bounce event on the same edge -> result 0 (clear wins).
- Button held through reset: after reset deasserts, the press is detected normally, with btnClean=0 after the full latency above. No press is lost and none is duplicated.
- Reset mid-CHK: the pending transition is discarded; the counter restarts from S_RELEASED.
- Counter never exceeds DEBOUNCE_CYCLES-1; no wrap-around is possible.

Test Plan:
Run with SYNC_STAGES=2, DEBOUNCE_CYCLES=4, CNT_WIDTH=3.
1. Clean press: btnRaw 1->0 sampled at edge 10, held -> btnClean 1->0 at edge 15. btnStable 0 on edges 12–14, 1 from edge 15. bounceCount=0.
2. Bounce rejected: btnRaw low for edges 10–12 then high -> btnClean stays 1. State returns to S_RELEASED. bounceCount=1.
3. Release with bounce: from pressed, btnRaw high 2 cycles, low 1 cycle, then high held -> btnClean stays 0 through the bounce, then rises 5 edges after the final high sample. bounceCount +1.
4. Saturation/clear: 260 rejected bounces -> bounceCount=255. Then bounceClr asserted on an edge that also has a bounce event -> bounceCount=0.
5. Async reset: assert reset mid-S_PRESS_CHK between clock edges -> btnClean=1, btnStable=1, bounceCount=0 immediately. Keep btnRaw=0 held through reset; after reset deasserts at edge r, btnClean falls at edge r+5.
6. Single-cycle glitch: btnRaw low for exactly 1 edge, repeated every 3 cycles for 30 cycles -> btnClean never changes. bounceCount counts each glitch.
